// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine transaction controller (coin credit, timed dispense, paced change/refund pulses)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_coin_half       one-cycle flag, 0.5-unit coin inserted
//   i_coin_one        one-cycle flag, 1-unit coin inserted
//   i_cancel          one-cycle flag, abort and refund credit
//   o_credit          credit (IDLE/DISPENSE) or remaining refund (CHANGE), in half-units
//   o_dispense        goods release, high for DISP_CYCLES cycles
//   o_change_pulse    one-cycle pulse per refunded half-unit
//   o_busy            high in DISPENSE or CHANGE; input flags ignored meanwhile
module vend_ctrl #(
  parameter int PRICE       = 5,
  parameter int CREDIT_W    = 4,
  parameter int DISP_CYCLES = 50_000_000,
  parameter int GAP         = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_coin_half,
  input  logic                i_coin_one,
  input  logic                i_cancel,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_dispense,
  output logic                o_change_pulse,
  output logic                o_busy
);
  localparam int DW = $clog2(DISP_CYCLES + 1);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {S_IDLE, S_DISP, S_CHG} state_t;
  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_dispense;
  logic                r_change_pulse;
  logic                r_busy;
  logic [DW-1:0]       r_disp_cnt;
  logic [GW-1:0]       r_gap_cnt;
  logic [CREDIT_W-1:0] w_sum;
  // both coin flags in the same cycle are counted together
  assign w_sum = r_credit + CREDIT_W'(i_coin_half) + CREDIT_W'({i_coin_one, 1'b0});
  assign o_credit       = r_credit;
  assign o_dispense     = r_dispense;
  assign o_change_pulse = r_change_pulse;
  assign o_busy         = r_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_dispense     <= 1'b0;
      r_change_pulse <= 1'b0;
      r_busy         <= 1'b0;
      r_disp_cnt     <= '0;
      r_gap_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_credit <= w_sum;
          if (i_cancel) begin
            r_state <= S_CHG;
            r_busy  <= 1'b1;
          end else if (w_sum >= CREDIT_W'(PRICE)) begin
            r_state    <= S_DISP;
            r_dispense <= 1'b1;
            r_busy     <= 1'b1;
            r_disp_cnt <= DW'(DISP_CYCLES - 1);
          end
        end
        S_DISP: begin
          if (r_disp_cnt == '0) begin
            r_dispense <= 1'b0;
            r_credit   <= r_credit - CREDIT_W'(PRICE);
            r_state    <= S_CHG;
          end else begin
            r_disp_cnt <= r_disp_cnt - DW'(1);
          end
        end
        S_CHG: begin
          // gap counter enters at 0 so the first pulse follows one cycle after entry
          if (r_credit == '0) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_change_pulse <= 1'b0;
            r_gap_cnt      <= '0;
          end else if (r_gap_cnt == '0) begin
            r_change_pulse <= 1'b1;
            r_credit       <= r_credit - CREDIT_W'(1);
            r_gap_cnt      <= GW'(GAP - 1);
          end else begin
            r_change_pulse <= 1'b0;
            r_gap_cnt      <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_credit       <= '0;
          r_dispense     <= 1'b0;
          r_change_pulse <= 1'b0;
          r_busy         <= 1'b0;
          r_disp_cnt     <= '0;
          r_gap_cnt      <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: self-checking bench for vend_ctrl against a schedule-based transaction model
module tb_vend_ctrl;
  localparam int PRICE = 5;
  localparam int D     = 4;
  localparam int GAP   = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_half = 1'b0;
  logic       coin_one = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] o_credit;
  logic       o_dispense;
  logic       o_change_pulse;
  logic       o_busy;
  int n_vec = 0;
  int n_bad = 0;
  vend_ctrl #(.PRICE(PRICE), .CREDIT_W(4), .DISP_CYCLES(D), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_coin_half(coin_half), .i_coin_one(coin_one), .i_cancel(cancel),
    .o_credit(o_credit), .o_dispense(o_dispense),
    .o_change_pulse(o_change_pulse), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  // Transaction model: a sale or cancel starting at edge s is described by when its
  // change phase begins (e), the refund amount (r) and the edge it returns to idle (endc).
  int  n = 0, s = 0, e = 0, endc = 0, r = 0, mcred = 0;
  bit  act = 1'b0, sale = 1'b0;
  int  m_sum, m_r, m_e;
  logic m_go;
  assign m_sum = mcred + int'(coin_half) + 2 * int'(coin_one);
  assign m_go  = !act && (cancel || m_sum >= PRICE);
  assign m_r   = cancel ? m_sum : m_sum - PRICE;
  assign m_e   = cancel ? n + 1 : n + 1 + D;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act   <= 1'b0;
      mcred <= 0;
      n     <= 0;
    end else begin
      n <= n + 1;
      if (act) begin
        if (n + 1 == endc) begin
          act   <= 1'b0;
          mcred <= 0;
        end
      end else begin
        mcred <= m_sum;
        if (m_go) begin
          act  <= 1'b1;
          sale <= !cancel;
          s    <= n + 1;
          e    <= m_e;
          r    <= m_r;
          endc <= (m_r == 0) ? m_e + 1 : m_e + 2 + (m_r - 1) * GAP;
        end
      end
    end
  end
  function automatic void expect_now(output int ec, output bit ed, output bit ep, output bit eb);
    int j, k;
    ec = mcred; ed = 0; ep = 0; eb = 0;
    if (act) begin
      eb = 1;
      if (sale && n < s + D) begin
        ed = 1;
      end else begin
        j = n - e;
        if (j == 0) ec = r;
        else begin
          k = (j - 1) / GAP + 1;
          if (k > r) k = r;
          ec = r - k;
          ep = ((j - 1) % GAP == 0) && ((j - 1) / GAP < r);
        end
      end
    end
  endfunction
  task automatic cmp_model();
    int ec; bit ed, ep, eb;
    expect_now(ec, ed, ep, eb);
    n_vec++;
    if (int'(o_credit) != ec || o_dispense != ed || o_change_pulse != ep || o_busy != eb) begin
      n_bad++;
      $display("FAIL model n=%0d credit=%0d/%0d dispense=%0b/%0b pulse=%0b/%0b busy=%0b/%0b (got/want)",
               n, o_credit, ec, o_dispense, ed, o_change_pulse, ep, o_busy, eb);
    end
  endtask
  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cmp_model();
  endtask
  task automatic apply(input bit h, input bit o, input bit c);
    coin_half = h; coin_one = o; cancel = c;
    tick();
    coin_half = 0; coin_one = 0; cancel = 0;
  endtask
  task automatic run(input int k, output int nd, output int np);
    nd = 0; np = 0;
    repeat (k) begin
      tick();
      nd += int'(o_dispense);
      np += int'(o_change_pulse);
    end
  endtask
  initial begin
    int nd, np;
    repeat (3) @(negedge clk);
    chk("rst_credit", int'(o_credit), 0);
    chk("rst_dispense", int'(o_dispense), 0);
    chk("rst_pulse", int'(o_change_pulse), 0);
    chk("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    tick();
    // exact pay
    apply(0, 1, 0); chk("exact_c1", int'(o_credit), 2);
    apply(0, 1, 0); chk("exact_c2", int'(o_credit), 4);
    apply(1, 0, 0); chk("exact_c3", int'(o_credit), 5);
    chk("exact_disp_on", int'(o_dispense), 1);
    run(12, nd, np);
    chk("exact_disp_len", nd + 1, 4);
    chk("exact_pulses", np, 0);
    chk("exact_end_busy", int'(o_busy), 0);
    chk("exact_end_credit", int'(o_credit), 0);
    // overpay
    repeat (3) apply(0, 1, 0);
    chk("over_credit", int'(o_credit), 6);
    run(4, nd, np);
    chk("over_disp_len", nd + 1, 4);
    chk("over_remaining", int'(o_credit), 1);
    run(10, nd, np);
    chk("over_pulses", np, 1);
    chk("over_end_credit", int'(o_credit), 0);
    chk("over_end_busy", int'(o_busy), 0);
    // simultaneous coins, then coin + cancel together
    apply(1, 1, 0); chk("simul_credit", int'(o_credit), 3);
    apply(0, 1, 1); chk("cancel_credit", int'(o_credit), 5);
    chk("cancel_busy", int'(o_busy), 1);
    nd = 0; np = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      nd += int'(o_dispense);
      if (o_change_pulse) begin
        chk("cancel_pulse_pos", t, 1 + GAP * np);
        chk("cancel_credit_step", int'(o_credit), 4 - np);
        np++;
      end
    end
    chk("cancel_pulses", np, 5);
    chk("cancel_no_disp", nd, 0);
    chk("cancel_end_busy", int'(o_busy), 0);
    // coin and cancel during busy are dropped
    repeat (3) apply(0, 1, 0);
    apply(0, 1, 0);
    apply(0, 0, 1);
    run(20, nd, np);
    chk("drop_pulses", np, 1);
    chk("drop_end_credit", int'(o_credit), 0);
    // zero-credit cancel
    apply(0, 0, 1);
    chk("zc_busy1", int'(o_busy), 1);
    chk("zc_credit", int'(o_credit), 0);
    chk("zc_pulse1", int'(o_change_pulse), 0);
    tick();
    chk("zc_busy2", int'(o_busy), 0);
    chk("zc_pulse2", int'(o_change_pulse), 0);
    // reset mid-dispense
    repeat (3) apply(0, 1, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_credit", int'(o_credit), 0);
    chk("arst_dispense", int'(o_dispense), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_pulse", int'(o_change_pulse), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after_credit", int'(o_credit), 0);
    chk("arst_after_busy", int'(o_busy), 0);
    // randomized traffic, occasional resets
    for (int i = 0; i < 3000; i++) begin
      coin_half = ($urandom_range(3) == 0);
      coin_one  = ($urandom_range(3) == 0);
      cancel    = ($urandom_range(15) == 0);
      rst_n     = ($urandom_range(399) != 0);
      tick();
    end
    coin_half = 0; coin_one = 0; cancel = 0; rst_n = 1'b1;
    repeat (40) tick();
    chk("final_idle_busy", int'(o_busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
